up_csr_bank: RTL and testbench
==============================

# up_csr_bank

Parametrised processor-interface register bank for the fractal core. It decodes the 8-bit byte-wide pi_* bus into control, status, interrupt and coordinate registers. It provides atomic multi-byte coordinate update and readback, and a level interrupt with acknowledge handshake. It sits between the host bus and the fractal engine, and is the synthesizable slave counterpart of the pi_* bus used by the bench.

## Interface
- DATA_W, 8: bus data width; byte lane width of every register.
- ADDR_W, 4: bus address width; register space is 2^ADDR_W locations.
- COORD_W, 16: coordinate width. Must be a multiple of DATA_W, with 4+2*COORD_W/DATA_W ≤ 2^ADDR_W−2.
- NUM_IRQ, 4: number of interrupt sources, ≤ DATA_W.
- ID_VAL, 8'hF5: constant returned by the ID register.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pi_blk_sel  in  1  block select; all accesses ignored when low.
- pi_addr  in  ADDR_W  register address.
- pi_wr_en  in  1  write strobe, one access per high cycle.
- pi_rd_en  in  1  read strobe, one access per high cycle.
- pi_wr_data  in  DATA_W  write data.
- pi_rd_data  out  DATA_W  registered read data.
- interrupt  out  1  level interrupt to host.
- interrupt_ack  in  1  host acknowledge pulse.
- irq_src  in  NUM_IRQ  event inputs, each high cycle is an event.
- core_busy  in  1  engine busy status.
- core_start  out  1  one-cycle start pulse.
- core_mode  out  3  engine mode.
- coord_x, coord_y  out  COORD_W  committed coordinates.
- coord_update  out  1  one-cycle pulse on commit.

## Operation
Register map (byte addresses; NB = COORD_W/DATA_W):
- 0x0 CTRL: bit0 start (write-1 pulses core_start; reads 0); bits[3:1] mode (RW → core_mode).
- 0x1 STATUS (RO): bit0 core_busy, bit1 interrupt, bit2 err (sticky). Reading STATUS clears err.
- 0x2 IRQ_EN (RW): [NUM_IRQ-1:0].
- 0x3 IRQ_PEND: reads pending bits. Write-1-to-clear.
- 0x4 .. 0x4+NB−1: X bytes, little-endian. 0x4+NB .. 0x4+2NB−1: Y bytes.
- 2^ADDR_W−2 ID (RO): ID_VAL.
- 2^ADDR_W−1 COMMIT (WO): any write commits shadows.

Access rules:
- Coordinate writes go to the shadow_x/shadow_y registers only. A COMMIT write copies both shadows to coord_x/coord_y in the same edge and pulses coord_update.
- Coordinate reads of byte 0 (X or Y) snapshot the full committed value. Higher bytes of that coordinate read from the snapshot, so a low-then-high read sequence is atomic.
- A start write while core_busy=1 is dropped: no pulse, and err is set.
- A write and a read in the same selected cycle: the write executes, the read is suppressed, and pi_rd_data holds.
- Unmapped reads return 0. Unmapped and RO writes are ignored.

Interrupts (up_irq_ctrl):
- pend[i] is set on any cycle irq_src[i]=1.
- interrupt = |(pend & en), registered.
- interrupt_ack clears the pend bits that are enabled at that edge.
- A set and a clear (W1C or ack) on the same bit in the same edge: set wins.
- Disabled bits stay pending and assert interrupt once enabled.

## Timing
- Reset values: all registers 0; pi_rd_data=0, interrupt=0, core_start=0, core_mode=0, coord_x/y=0, coord_update=0.
- Reset mid-operation clears pending, shadows and snapshot immediately (asynchronous).
- Read latency: the edge sampling pi_rd_en loads pi_rd_data. Data is valid from that edge until the next read.
- Write effect is visible on the sampling edge: core_start/coord_update are high for exactly the following cycle.
- irq_src at edge N → pend at N → interrupt high after edge N+1.
- interrupt_ack at edge M → interrupt low after edge M+1, unless a new event is set at M.

## Structure
- Package up_csr_pkg holds:
  - register address localparams, written as offsets from ADDR_W/NB;
  - the CTRL/STATUS bit-position constants;
  - a typedef for CTRL fields.
- Sub-module up_irq_ctrl (NUM_IRQ): pend/en/W1C/ack logic and the registered interrupt.
- Top-level contents: decode, shadows, snapshot, read mux.

## Test plan
- Reset then read ID, STATUS and IRQ_EN → 0xF5, 0x00, 0x00; all outputs 0.
- Write X=0x1234, Y=0xABCD bytewise, then read X/Y → 0 (not committed). Write COMMIT → coord_update for 1 cycle; coord_x=0x1234, coord_y=0xABCD.
- Snapshot: read X byte0 (0x34). Commit X=0x5678 between the byte0 and byte1 reads. Byte1 read → 0x12.
- Start: write CTRL=0x05 with busy=0 → core_start 1 cycle, core_mode=2. Repeat with busy=1 → no pulse, STATUS=0x05. Next STATUS read → 0x01.
- IRQ: IRQ_EN=0x3. Pulse irq_src=0x4 → pend=0x4, interrupt=0. Pulse irq_src=0x1 → interrupt=1. Ack → pend=0x4, interrupt=0. Enable bit2 → interrupt=1. W1C 0x4 → interrupt=0.
- Same-cycle irq_src[0] and ack → pend[0] stays 1. Same-cycle wr+rd → write applied, pi_rd_data unchanged. Assert rst_n low mid-sequence → all outputs 0 immediately.

Source files
------------

// File: rtl/up_csr_pkg.sv
// Shared register map, field positions and CTRL layout for the processor-interface CSR bank.
package up_csr_pkg;

  // Fixed low part of the map; coordinate bytes start at ADDR_COORD_BASE.
  localparam int ADDR_CTRL       = 0;
  localparam int ADDR_STATUS     = 1;
  localparam int ADDR_IRQ_EN     = 2;
  localparam int ADDR_IRQ_PEND   = 3;
  localparam int ADDR_COORD_BASE = 4;

  // CTRL / STATUS bit positions.
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_MODE_LSB  = 1;
  localparam int CTRL_MODE_W    = 3;
  localparam int CTRL_W         = 4;
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_IRQ_BIT   = 1;
  localparam int STAT_ERR_BIT   = 2;

  typedef struct packed {
    logic [CTRL_MODE_W-1:0] mode;
    logic                   start;
  } ctrl_t;

  // Y bytes follow the NB bytes of X.
  function automatic int addr_y_base(input int nb);
    return ADDR_COORD_BASE + nb;
  endfunction

  // ID and COMMIT sit at the top of the address space.
  function automatic int addr_id(input int aw);
    return (1 << aw) - 2;
  endfunction

  function automatic int addr_commit(input int aw);
    return (1 << aw) - 1;
  endfunction

endpackage

// File: rtl/up_irq_ctrl.sv
// Pending/enable interrupt bookkeeping with W1C, acknowledge and a registered level output.
module up_irq_ctrl #(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_we,
  input  logic [NUM_IRQ-1:0] en_wdata,
  input  logic               w1c_we,
  input  logic [NUM_IRQ-1:0] w1c_data,
  input  logic               ack,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic [NUM_IRQ-1:0] en,
  output logic [NUM_IRQ-1:0] pend,
  output logic               interrupt
);

  logic [NUM_IRQ-1:0] clr;

  // Ack only clears the sources that are enabled at the acknowledging edge.
  assign clr = (w1c_we ? w1c_data : '0) | (ack ? en : '0);

  // New events are OR-ed in after the clear so a same-edge set always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en        <= '0;
      pend      <= '0;
      interrupt <= 1'b0;
    end else begin
      if (en_we) en <= en_wdata;
      pend      <= (pend & ~clr) | irq_src;
      interrupt <= |(pend & en);
    end
  end

endmodule

// File: rtl/up_csr_bank.sv
// Byte-wide pi_* slave: control/status, interrupts and atomic coordinate shadow/commit/snapshot.
module up_csr_bank
  import up_csr_pkg::*;
#(
  parameter int               DATA_W  = 8,
  parameter int               ADDR_W  = 4,
  parameter int               COORD_W = 16,
  parameter int               NUM_IRQ = 4,
  parameter logic [DATA_W-1:0] ID_VAL = 8'hF5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pi_blk_sel,
  input  logic [ADDR_W-1:0]  pi_addr,
  input  logic               pi_wr_en,
  input  logic               pi_rd_en,
  input  logic [DATA_W-1:0]  pi_wr_data,
  output logic [DATA_W-1:0]  pi_rd_data,
  output logic               interrupt,
  input  logic               interrupt_ack,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               core_busy,
  output logic               core_start,
  output logic [2:0]         core_mode,
  output logic [COORD_W-1:0] coord_x,
  output logic [COORD_W-1:0] coord_y,
  output logic               coord_update
);

  localparam int NB = COORD_W / DATA_W;

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(ADDR_CTRL);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(ADDR_STATUS);
  localparam logic [ADDR_W-1:0] A_IRQ_EN = ADDR_W'(ADDR_IRQ_EN);
  localparam logic [ADDR_W-1:0] A_PEND   = ADDR_W'(ADDR_IRQ_PEND);
  localparam logic [ADDR_W-1:0] A_X      = ADDR_W'(ADDR_COORD_BASE);
  localparam logic [ADDR_W-1:0] A_Y      = ADDR_W'(addr_y_base(NB));
  localparam logic [ADDR_W-1:0] A_ID     = ADDR_W'(addr_id(ADDR_W));
  localparam logic [ADDR_W-1:0] A_COMMIT = ADDR_W'(addr_commit(ADDR_W));

  logic                       wr_acc, rd_acc;
  logic                       err;
  logic [COORD_W-1:0]         shadow_x, shadow_y;
  // Only the upper bytes need a snapshot; byte 0 is returned live while the snapshot is taken.
  logic [COORD_W-DATA_W-1:0]  snap_x, snap_y;
  logic [NUM_IRQ-1:0]         irq_en, irq_pend;
  logic [DATA_W-1:0]          rd_val;
  ctrl_t                      ctrl_wr;

  // A write in the same cycle as a read wins; the read is dropped.
  assign wr_acc  = pi_blk_sel && pi_wr_en;
  assign rd_acc  = pi_blk_sel && pi_rd_en && !pi_wr_en;
  assign ctrl_wr = ctrl_t'(pi_wr_data[CTRL_W-1:0]);

  up_irq_ctrl #(.NUM_IRQ(NUM_IRQ)) u_irq (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_we     (wr_acc && (pi_addr == A_IRQ_EN)),
    .en_wdata  (pi_wr_data[NUM_IRQ-1:0]),
    .w1c_we    (wr_acc && (pi_addr == A_PEND)),
    .w1c_data  (pi_wr_data[NUM_IRQ-1:0]),
    .ack       (interrupt_ack),
    .irq_src   (irq_src),
    .en        (irq_en),
    .pend      (irq_pend),
    .interrupt (interrupt)
  );

  // Read data mux; unmapped and write-only locations read as zero.
  always_comb begin
    rd_val = '0;
    if (pi_addr == A_CTRL) begin
      rd_val[CTRL_MODE_LSB +: CTRL_MODE_W] = core_mode;
    end
    if (pi_addr == A_STATUS) begin
      rd_val[STAT_BUSY_BIT] = core_busy;
      rd_val[STAT_IRQ_BIT]  = interrupt;
      rd_val[STAT_ERR_BIT]  = err;
    end
    if (pi_addr == A_IRQ_EN) rd_val[NUM_IRQ-1:0] = irq_en;
    if (pi_addr == A_PEND)   rd_val[NUM_IRQ-1:0] = irq_pend;
    if (pi_addr == A_X)      rd_val = coord_x[DATA_W-1:0];
    if (pi_addr == A_Y)      rd_val = coord_y[DATA_W-1:0];
    for (int b = 1; b < NB; b++) begin
      if (pi_addr == A_X + ADDR_W'(b)) rd_val = snap_x[(b-1)*DATA_W +: DATA_W];
      if (pi_addr == A_Y + ADDR_W'(b)) rd_val = snap_y[(b-1)*DATA_W +: DATA_W];
    end
    if (pi_addr == A_ID) rd_val = ID_VAL;
  end

  // Register writes, commit, snapshot capture and registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pi_rd_data   <= '0;
      core_start   <= 1'b0;
      core_mode    <= '0;
      err          <= 1'b0;
      shadow_x     <= '0;
      shadow_y     <= '0;
      coord_x      <= '0;
      coord_y      <= '0;
      snap_x       <= '0;
      snap_y       <= '0;
      coord_update <= 1'b0;
    end else begin
      core_start   <= 1'b0;
      coord_update <= 1'b0;
      if (wr_acc) begin
        if (pi_addr == A_CTRL) begin
          core_mode <= ctrl_wr.mode;
          if (ctrl_wr.start) begin
            if (core_busy) err <= 1'b1;
            else           core_start <= 1'b1;
          end
        end
        for (int b = 0; b < NB; b++) begin
          if (pi_addr == A_X + ADDR_W'(b)) shadow_x[b*DATA_W +: DATA_W] <= pi_wr_data;
          if (pi_addr == A_Y + ADDR_W'(b)) shadow_y[b*DATA_W +: DATA_W] <= pi_wr_data;
        end
        if (pi_addr == A_COMMIT) begin
          coord_x      <= shadow_x;
          coord_y      <= shadow_y;
          coord_update <= 1'b1;
        end
      end
      if (rd_acc) begin
        pi_rd_data <= rd_val;
        if (pi_addr == A_STATUS) err    <= 1'b0;
        if (pi_addr == A_X)      snap_x <= coord_x[COORD_W-1:DATA_W];
        if (pi_addr == A_Y)      snap_y <= coord_y[COORD_W-1:DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_up_csr_bank.sv
// Randomised + directed bench for up_csr_bank with a per-cycle expected-output scoreboard.
module tb_up_csr_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pi_blk_sel = 1'b0;
  logic [3:0]  pi_addr = '0;
  logic        pi_wr_en = 1'b0;
  logic        pi_rd_en = 1'b0;
  logic [7:0]  pi_wr_data = '0;
  logic [7:0]  pi_rd_data;
  logic        interrupt;
  logic        interrupt_ack = 1'b0;
  logic [3:0]  irq_src = '0;
  logic        core_busy = 1'b0;
  logic        core_start;
  logic [2:0]  core_mode;
  logic [15:0] coord_x, coord_y;
  logic        coord_update;

  always #5 clk = ~clk;

  up_csr_bank dut (
    .clk(clk), .rst_n(rst_n), .pi_blk_sel(pi_blk_sel), .pi_addr(pi_addr),
    .pi_wr_en(pi_wr_en), .pi_rd_en(pi_rd_en), .pi_wr_data(pi_wr_data),
    .pi_rd_data(pi_rd_data), .interrupt(interrupt), .interrupt_ack(interrupt_ack),
    .irq_src(irq_src), .core_busy(core_busy), .core_start(core_start),
    .core_mode(core_mode), .coord_x(coord_x), .coord_y(coord_y),
    .coord_update(coord_update)
  );

  typedef struct {
    int rd; int start; int mode; int cx; int cy; int upd; int intr;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  // Reference state kept as plain integers.
  int m_mode, m_err, m_en, m_pend, m_int, m_rd;
  int shx, shy, cx, cy, snx, sny;
  bit busy_g = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_err = 0; m_en = 0; m_pend = 0; m_int = 0; m_rd = 0;
    shx = 0; shy = 0; cx = 0; cy = 0; snx = 0; sny = 0;
  endtask

  function automatic int set_byte(input int v, input int k, input int d);
    return ((v & ~(255 << (8 * k))) | ((d & 255) << (8 * k))) & 16'hFFFF;
  endfunction

  function automatic int get_byte(input int v, input int k);
    return (v >> (8 * k)) & 255;
  endfunction

  // Called at the sampling edge: predicts what the outputs show after it.
  task automatic model_step();
    int a, d, clr, start, upd, nint;
    bit w, r;
    exp_t e;
    a = int'(pi_addr);
    d = int'(pi_wr_data);
    w = pi_blk_sel && pi_wr_en;
    r = pi_blk_sel && pi_rd_en && !pi_wr_en;
    nint = ((m_pend & m_en) != 0) ? 1 : 0;
    clr = interrupt_ack ? m_en : 0;
    start = 0;
    upd = 0;
    if (r) begin
      case (a)
        0:  m_rd = m_mode * 2;
        1:  begin m_rd = int'(core_busy) + 2 * m_int + 4 * m_err; m_err = 0; end
        2:  m_rd = m_en;
        3:  m_rd = m_pend;
        4:  begin snx = cx; m_rd = get_byte(cx, 0); end
        5:  m_rd = get_byte(snx, 1);
        6:  begin sny = cy; m_rd = get_byte(cy, 0); end
        7:  m_rd = get_byte(sny, 1);
        14: m_rd = 8'hF5;
        default: m_rd = 0;
      endcase
    end
    if (w) begin
      case (a)
        0: begin
          m_mode = (d >> 1) & 7;
          if ((d & 1) != 0) begin
            if (core_busy) m_err = 1;
            else           start = 1;
          end
        end
        2:  m_en = d & 15;
        3:  clr = clr | (d & 15);
        4, 5: shx = set_byte(shx, a - 4, d);
        6, 7: shy = set_byte(shy, a - 6, d);
        15: begin cx = shx; cy = shy; upd = 1; end
        default: ;
      endcase
    end
    m_pend = ((m_pend & ~clr) | int'(irq_src)) & 15;
    m_int = nint;
    e.rd = m_rd; e.start = start; e.mode = m_mode; e.cx = cx; e.cy = cy;
    e.upd = upd; e.intr = m_int;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit s, input bit w, input bit r, input int a, input int d,
                     input int src, input bit ack);
    @(negedge clk);
    pi_blk_sel = s; pi_wr_en = w; pi_rd_en = r;
    pi_addr = 4'(a); pi_wr_data = 8'(d); irq_src = 4'(src);
    interrupt_ack = ack; core_busy = busy_g;
    @(posedge clk);
    model_step();
  endtask

  task automatic wr(input int a, input int d); cyc(1, 1, 0, a, d, 0, 0); endtask
  task automatic rd(input int a);              cyc(1, 0, 1, a, 0, 0, 0); endtask
  task automatic idle();                       cyc(0, 0, 0, 0, 0, 0, 0); endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_data"}, 32'(pi_rd_data), 0);
    chk({tag, "_interrupt"}, 32'(interrupt), 0);
    chk({tag, "_core_start"}, 32'(core_start), 0);
    chk({tag, "_core_mode"}, 32'(core_mode), 0);
    chk({tag, "_coord_x"}, 32'(coord_x), 0);
    chk({tag, "_coord_y"}, 32'(coord_y), 0);
    chk({tag, "_coord_update"}, 32'(coord_update), 0);
  endtask

  task automatic random_phase(input int n);
    int src;
    for (int i = 0; i < n; i++) begin
      src = 0;
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) src = src | (1 << b);
      busy_g = ($urandom_range(1) == 1);
      cyc($urandom_range(9) != 0, $urandom_range(9) < 3, $urandom_range(9) < 5,
          int'($urandom_range(15)), int'($urandom_range(255)), src,
          $urandom_range(9) == 0);
    end
  endtask

  // Monitor: every output is compared after each sampling edge that has a prediction.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_data", 32'(pi_rd_data), 32'(e.rd));
        chk("core_start", 32'(core_start), 32'(e.start));
        chk("core_mode", 32'(core_mode), 32'(e.mode));
        chk("coord_x", 32'(coord_x), 32'(e.cx));
        chk("coord_y", 32'(coord_y), 32'(e.cy));
        chk("coord_update", 32'(coord_update), 32'(e.upd));
        chk("interrupt", 32'(interrupt), 32'(e.intr));
      end
    end
  end

  initial begin : stim
    model_reset();
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    rd(14); rd(1); rd(2);
    wr(4, 8'h34); wr(5, 8'h12); wr(6, 8'hCD); wr(7, 8'hAB);
    rd(4); rd(5); rd(6);
    wr(15, 0); idle();
    rd(4);
    wr(4, 8'h78); wr(5, 8'h56); wr(15, 0);
    rd(5); rd(4); rd(5);

    busy_g = 0; wr(0, 8'h05); idle();
    busy_g = 1; wr(0, 8'h05); rd(1); rd(1);
    busy_g = 0; rd(0);

    wr(2, 8'h03);
    cyc(0, 0, 0, 0, 0, 4'h4, 0); idle(); rd(3);
    cyc(0, 0, 0, 0, 0, 4'h1, 0); idle(); idle();
    cyc(0, 0, 0, 0, 0, 0, 1); idle(); rd(3);
    wr(2, 8'h07); idle(); idle();
    wr(3, 8'h04); idle(); idle();

    cyc(0, 0, 0, 0, 0, 4'h1, 1); idle(); rd(3);
    cyc(1, 0, 0, 0, 0, 4'h2, 0); wr(3, 8'h0F); rd(3);
    cyc(1, 1, 0, 3, 8'h01, 4'h1, 0); rd(3);

    rd(14);
    cyc(1, 1, 1, 0, 8'h0A, 0, 0); rd(0);
    cyc(0, 1, 0, 2, 8'h0F, 0, 0); rd(2);
    rd(9); rd(15);

    random_phase(1500);

    @(negedge clk);
    pi_blk_sel = 0; pi_wr_en = 0; pi_rd_en = 0; irq_src = '0; interrupt_ack = 0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd(4); rd(3);

    random_phase(400);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
